// File: rtl/gf2_ge_pkg.sv
// Shared types and helpers for the GF(2) Gaussian-elimination engine.
//   state_e       : engine FSM states
//   MODE_*        : elimination mode encodings (latched at start)
//   idx_w()       : index width for a counter spanning 0..n-1 (minimum 1 bit)
package gf2_ge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ELIM = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam logic MODE_ECHELON = 1'b0;
    localparam logic MODE_REDUCED = 1'b1;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf2_pivot_find.sv
// Combinational pivot search: lowest row index >= r whose column bit is set.
//   col_bits : bit i is row i's bit in the current column
//   r        : first row eligible as pivot
//   found    : a pivot exists
//   p        : pivot row index (valid when found)
module gf2_pivot_find
    import gf2_ge_pkg::*;
#(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned RANK_W = idx_w(ROWS + 1),
    parameter int unsigned ROW_W  = idx_w(ROWS)
) (
    input  logic [ROWS-1:0]   col_bits,
    input  logic [RANK_W-1:0] r,
    output logic              found,
    output logic [ROW_W-1:0]  p
);

    // Scan from the top so the lowest qualifying index wins.
    always_comb begin
        found = 1'b0;
        p     = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (col_bits[i] && (RANK_W'(i) >= r)) begin
                found = 1'b1;
                p     = ROW_W'(i);
            end
        end
    end

endmodule

// File: rtl/gf2_gauss_engine.sv
// GF(2) Gaussian elimination: load ROWS x COLS matrix row by row, reduce one
// column per cycle (echelon or reduced form), stream rows out, report rank.
//   clk, rst_b              : clock, async active-low reset
//   start, mode             : begin job (IDLE only); 0 echelon, 1 reduced
//   in_data/in_valid/in_ready    : row input stream (bit COLS-1 is column 0)
//   out_data/out_valid/out_ready : result row stream with backpressure
//   busy, done              : not idle; one-cycle pulse on first OUT cycle
//   rank, full_rank         : pivot count; rank == min(ROWS, COLS)
module gf2_gauss_engine
    import gf2_ge_pkg::*;
#(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned COLS   = 16,
    parameter int unsigned RANK_W = idx_w(ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              mode,
    input  logic [COLS-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [COLS-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [RANK_W-1:0] rank,
    output logic              full_rank
);

    localparam int unsigned ROW_W  = idx_w(ROWS);
    localparam int unsigned COL_W  = idx_w(COLS);
    localparam int unsigned MIN_RC = (ROWS < COLS) ? ROWS : COLS;

    state_e            state;
    logic              mode_q;
    logic [ROW_W-1:0]  k;
    logic [COL_W-1:0]  c;
    logic [RANK_W-1:0] r;
    logic [COLS-1:0]   rows_q    [ROWS];
    logic [COLS-1:0]   elim_rows [ROWS];
    logic [ROWS-1:0]   col_bits;
    logic [COL_W-1:0]  col_pos;
    logic              piv_found;
    logic [ROW_W-1:0]  piv_p;
    logic              elim_last;
    logic [RANK_W-1:0] rank_inc;

    // Column c maps to bit COLS-1-c of each row.
    always_comb begin
        col_pos = COL_W'(COLS - 1) - c;
        for (int i = 0; i < ROWS; i++) begin
            col_bits[i] = rows_q[i][col_pos];
        end
    end

    gf2_pivot_find #(
        .ROWS   (ROWS),
        .RANK_W (RANK_W),
        .ROW_W  (ROW_W)
    ) u_pivot (
        .col_bits (col_bits),
        .r        (r),
        .found    (piv_found),
        .p        (piv_p)
    );

    // Swap pivot into row r, then clear column c from the selected rows.
    always_comb begin
        logic [COLS-1:0] piv_row;
        logic [COLS-1:0] r_row;
        logic [COLS-1:0] v;
        logic [ROW_W-1:0] r_idx;
        r_idx   = ROW_W'(r);
        piv_row = rows_q[piv_p];
        r_row   = rows_q[r_idx];
        v       = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (ROW_W'(i) == r_idx) begin
                v = piv_row;
            end else if (ROW_W'(i) == piv_p) begin
                v = r_row;
            end else begin
                v = rows_q[i];
            end
            if ((ROW_W'(i) != r_idx) && v[col_pos] &&
                ((mode_q == MODE_REDUCED) || (RANK_W'(i) > r))) begin
                v = v ^ piv_row;
            end
            elim_rows[i] = v;
        end
    end

    assign rank_inc  = rank + 1'b1;
    assign elim_last = (c == COL_W'(COLS - 1)) ||
                       (piv_found && (r == RANK_W'(ROWS - 1)));

    // FSM, matrix storage, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            mode_q    <= MODE_ECHELON;
            k         <= '0;
            c         <= '0;
            r         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rank      <= '0;
            full_rank <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        k         <= '0;
                        c         <= '0;
                        r         <= '0;
                        rank      <= '0;
                        full_rank <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        rows_q[k] <= in_data;
                        if (k == ROW_W'(ROWS - 1)) begin
                            k        <= '0;
                            in_ready <= 1'b0;
                            state    <= ELIM;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                ELIM: begin
                    c <= c + 1'b1;
                    if (piv_found) begin
                        rows_q    <= elim_rows;
                        r         <= r + 1'b1;
                        rank      <= rank_inc;
                        full_rank <= (rank_inc == RANK_W'(MIN_RC));
                    end
                    if (elim_last) begin
                        k         <= '0;
                        out_data  <= piv_found ? elim_rows[0] : rows_q[0];
                        out_valid <= 1'b1;
                        done      <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        if (k == ROW_W'(ROWS - 1)) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            k        <= k + 1'b1;
                            out_data <= rows_q[k + 1'b1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
